// File: rtl/demuxl2_lane_ctrl_pkg.sv
// Shared types and defaults for the two-lane byte striper.
// State encodings are one-hot so the state port can be decoded directly by the lane demuxes.
package demuxl2_lane_ctrl_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_SYNC = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

endpackage

// File: rtl/demuxl2_lane_ctrl_if.sv
// Byte-stream input and two-lane output bundle of the lane controller.
// The master side is the byte source; the slave side is the controller.
interface demuxl2_lane_ctrl_if
    import demuxl2_lane_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic [WIDTH-1:0] data_00;
    logic             valid_00;
    logic [WIDTH-1:0] data_11;
    logic             valid_11;
    logic             phase_2f;
    logic             sel;
    state_t           state;

    modport master (
        output data_in, valid_in,
        input  data_00, valid_00, data_11, valid_11, phase_2f, sel, state
    );

    modport slave (
        input  data_in, valid_in,
        output data_00, valid_00, data_11, valid_11, phase_2f, sel, state
    );
endinterface

// File: rtl/demuxl2_lane_reg.sv
// Purpose: W-bit register with load enable and async active-low clear.
// Latency: 1 cycle from ld to q.
// Backpressure: none; loads whenever ld is high.
module demuxl2_lane_reg #(
    parameter int W = 9
) (
    input  logic         clk_4f,
    input  logic         reset_L,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end
endmodule

// File: rtl/demuxl2_lane_ctrl.sv
// Purpose: stripe a clk_4f byte stream onto lanes 00/11, committing pairs on a phase strobe.
// Latency: lane0 byte at t, lane1 byte at t+1 -> both lanes valid t+2..t+3.
// Backpressure: none; invalid slots pass through with valid=0, long idle drops to SYNC.
module demuxl2_lane_ctrl
    import demuxl2_lane_ctrl_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int IDLE_LIMIT = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk_4f,
    input  logic             reset_L,
    demuxl2_lane_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(IDLE_LIMIT);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] idle_q, idle_d, idle_upd;
    logic             hold_ld, lane_ld;
    logic [WIDTH:0]   in_word, hold_q, lane0_q, lane1_q;

    assign in_word = {bus.data_in, bus.valid_in};

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_SYNC;
            sel_q   <= 1'b0;
            phase_q <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            phase_q <= phase_d;
            idle_q  <= idle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        phase_d  = 1'b0;
        idle_d   = idle_q;
        hold_ld  = 1'b0;
        lane_ld  = 1'b0;
        // Saturating idle count; with a zero limit it simply stays at zero.
        idle_upd = bus.valid_in ? '0 : ((idle_q >= LIM) ? LIM : idle_q + CNT_W'(1));
        case (state_q)
            ST_SYNC: begin
                if (bus.valid_in) begin
                    hold_ld = 1'b1;
                    sel_d   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                idle_d = idle_upd;
                sel_d  = ~sel_q;
                if (!sel_q) begin
                    hold_ld = 1'b1;
                end else begin
                    lane_ld = 1'b1;
                    phase_d = 1'b1;
                    // The pair is committed before falling back to alignment.
                    if ((IDLE_LIMIT != 0) && (idle_upd >= LIM)) begin
                        state_d = ST_SYNC;
                        sel_d   = 1'b0;
                        idle_d  = '0;
                    end
                end
            end
            default: begin
                state_d = ST_SYNC;
                sel_d   = 1'b0;
                idle_d  = '0;
            end
        endcase
    end

    demuxl2_lane_reg #(.W(WIDTH + 1)) u_hold0 (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .ld      (hold_ld),
        .d       (in_word),
        .q       (hold_q)
    );

    demuxl2_lane_reg #(.W(WIDTH + 1)) u_lane00 (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .ld      (lane_ld),
        .d       (hold_q),
        .q       (lane0_q)
    );

    demuxl2_lane_reg #(.W(WIDTH + 1)) u_lane11 (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .ld      (lane_ld),
        .d       (in_word),
        .q       (lane1_q)
    );

    assign bus.data_00  = lane0_q[WIDTH:1];
    assign bus.valid_00 = lane0_q[0];
    assign bus.data_11  = lane1_q[WIDTH:1];
    assign bus.valid_11 = lane1_q[0];
    assign bus.phase_2f = phase_q;
    assign bus.sel      = sel_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_demuxl2_lane_ctrl.sv
// Directed and random stimulus for demuxl2_lane_ctrl against a pair-level reference model.
module tb_demuxl2_lane_ctrl;
    import demuxl2_lane_ctrl_pkg::*;

    localparam int W   = 8;
    localparam int LIM = 4;

    logic clk_4f = 1'b0;
    logic reset_L;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: aligned flag, slot within pair, pending lane0 byte, run of invalid bytes.
    bit         m_run, m_slot, m_ph;
    int         m_idle;
    logic [7:0] m_hd, m_d0, m_d1;
    logic       m_hv, m_v0, m_v1;

    demuxl2_lane_ctrl_if #(.WIDTH(W)) bus ();

    demuxl2_lane_ctrl #(.WIDTH(W), .IDLE_LIMIT(LIM), .CNT_W(3)) dut (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_slot = 0; m_ph = 0; m_idle = 0;
        m_hd = '0; m_hv = 0; m_d0 = '0; m_v0 = 0; m_d1 = '0; m_v1 = 0;
    endtask

    task automatic model_edge(input logic [7:0] d, input logic v);
        if (!reset_L) begin
            model_reset();
        end else if (!m_run) begin
            m_ph = 0;
            if (v) begin
                m_hd = d; m_hv = 1'b1; m_run = 1; m_slot = 1; m_idle = 0;
            end
        end else begin
            m_idle = v ? 0 : m_idle + 1;
            if (!m_slot) begin
                m_hd = d; m_hv = v; m_slot = 1; m_ph = 0;
            end else begin
                m_d0 = m_hd; m_v0 = m_hv; m_d1 = d; m_v1 = v; m_ph = 1; m_slot = 0;
                if (LIM != 0 && m_idle >= LIM) begin
                    m_run = 0; m_idle = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data_00"},  16'(bus.data_00),  16'(m_d0));
        chk({tag, ".valid_00"}, 16'(bus.valid_00), 16'(m_v0));
        chk({tag, ".data_11"},  16'(bus.data_11),  16'(m_d1));
        chk({tag, ".valid_11"}, 16'(bus.valid_11), 16'(m_v1));
        chk({tag, ".phase_2f"}, 16'(bus.phase_2f), 16'(m_ph));
        chk({tag, ".sel"},      16'(bus.sel),      16'(m_run && m_slot));
        chk({tag, ".state"},    16'(bus.state),    m_run ? 16'(ST_RUN) : 16'(ST_SYNC));
    endtask

    task automatic cyc(input string tag, input logic [7:0] d, input logic v);
        bus.data_in  = d;
        bus.valid_in = v;
        @(posedge clk_4f);
        model_edge(d, v);
        #1;
        check_all(tag);
    endtask

    initial begin
        int inv_run;
        logic v;
        reset_L      = 1'b0;
        bus.data_in  = '0;
        bus.valid_in = 1'b0;
        model_reset();

        // T1: reset held with valid traffic
        for (int i = 0; i < 3; i++) cyc("t1", 8'($urandom), 1'b1);
        reset_L = 1'b1;

        // T2: invalid bytes ignored in SYNC, then first pair
        for (int i = 0; i < 4; i++) cyc("t2_idle", 8'($urandom), 1'b0);
        chk("t2_sync", 16'(bus.state), 16'(ST_SYNC));
        cyc("t2_ff", 8'hff, 1'b1);
        chk("t2_run", 16'(bus.state), 16'(ST_RUN));
        cyc("t2_dd", 8'hdd, 1'b1);
        chk("t2_d00", 16'(bus.data_00), 16'h00ff);
        chk("t2_d11", 16'(bus.data_11), 16'h00dd);
        chk("t2_ph",  16'(bus.phase_2f), 16'h1);

        // T3: back-to-back valid pairs
        cyc("t3", 8'hee, 1'b1);
        chk("t3_ph0", 16'(bus.phase_2f), 16'h0);
        chk("t3_hold", 16'(bus.data_00), 16'h00ff);
        cyc("t3", 8'hcc, 1'b1);
        cyc("t3", 8'hbb, 1'b1);
        cyc("t3", 8'h99, 1'b1);
        chk("t3_d00", 16'(bus.data_00), 16'h00bb);
        cyc("t3", 8'haa, 1'b1);
        cyc("t3", 8'h88, 1'b1);

        // T4: invalid lane0 slot still passes its data
        cyc("t4", 8'h55, 1'b0);
        cyc("t4", 8'h77, 1'b1);
        chk("t4_d00", 16'(bus.data_00), 16'h0055);
        chk("t4_v00", 16'(bus.valid_00), 16'h0);
        chk("t4_d11", 16'(bus.data_11), 16'h0077);
        chk("t4_run", 16'(bus.state), 16'(ST_RUN));

        // T5: idle limit forces re-sync, next valid byte realigns to lane 0
        for (int i = 0; i < 4; i++) cyc("t5_idle", 8'($urandom), 1'b0);
        chk("t5_sync", 16'(bus.state), 16'(ST_SYNC));
        cyc("t5", 8'h3c, 1'b1);
        cyc("t5", 8'h11, 1'b1);
        chk("t5_d00", 16'(bus.data_00), 16'h003c);
        for (int i = 0; i < 3; i++) cyc("t5_odd", 8'($urandom), 1'b0);
        cyc("t5_odd", 8'h66, 1'b1);
        chk("t5_odd_run", 16'(bus.state), 16'(ST_RUN));

        // T6: async reset mid-pair discards the held lane0 byte
        cyc("t6", 8'h42, 1'b1);
        #2 reset_L = 1'b0;
        model_reset();
        #1 check_all("t6_async");
        cyc("t6_hold", 8'($urandom), 1'b1);
        reset_L = 1'b1;
        cyc("t6", 8'ha5, 1'b1);
        cyc("t6", 8'hb6, 1'b1);
        chk("t6_d00", 16'(bus.data_00), 16'h00a5);
        chk("t6_d11", 16'(bus.data_11), 16'h00b6);

        // Random traffic with idle bursts and occasional resets
        inv_run = 0;
        for (int i = 0; i < 600; i++) begin
            if (inv_run > 0) begin
                v = 1'b0;
                inv_run--;
            end else begin
                if ($urandom_range(0, 9) == 0) inv_run = $urandom_range(1, 7);
                v = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 149) == 0) reset_L = 1'b0;
            cyc("rand", 8'($urandom), v);
            reset_L = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
